// File: rtl/spi_pkg.sv
// spi_pkg: state encoding and default sizing shared by
// the SPI command scheduler and its bench.
package spi_pkg;

  localparam int DEF_TX_DEPTH = 8;
  localparam int DEF_MIN_GAP  = 2;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;
  localparam logic [1:0] ST_GAP   = 2'd3;

endpackage

// File: rtl/spi_cmd_scheduler.sv
// spi_cmd_scheduler: paces host words into an SPI controller
// FIFO, tracking credits with chip-select frame ends.
module spi_cmd_scheduler
  import spi_pkg::*;
#(
  parameter int TX_DEPTH = DEF_TX_DEPTH,
  parameter int MIN_GAP  = DEF_MIN_GAP
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cmd_valid,
  input  logic [31:0]                   cmd_data,
  output logic                          cmd_ready,
  input  logic                          spi_cs,
  output logic                          trigger,
  output logic [31:0]                   to_device,
  output logic [$clog2(TX_DEPTH+1)-1:0] outstanding,
  output logic [15:0]                   frames_done,
  output logic                          idle
);

  localparam int OW = $clog2(TX_DEPTH + 1);
  localparam logic [OW-1:0] FULL = OW'(TX_DEPTH);
  // GAP lasts MIN_GAP-1 cycles: load N-2, leave on zero
  localparam logic [7:0] GAP_LOAD = 8'(MIN_GAP - 2);

  logic [1:0] state;
  logic [7:0] gap_cnt;
  logic       spi_cs_q;
  logic       frame_end;
  logic       accept;
  logic       issue;

  assign frame_end = spi_cs & ~spi_cs_q;
  assign cmd_ready = ~rst & (state == ST_IDLE)
                   & (outstanding < FULL);
  assign accept    = cmd_valid & cmd_ready;
  assign issue     = ~rst & (state == ST_ISSUE);
  assign trigger   = issue;
  assign idle      = (state == ST_IDLE)
                   & (outstanding == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      gap_cnt   <= '0;
      to_device <= '0;
      spi_cs_q  <= 1'b1;
    end else begin
      spi_cs_q <= spi_cs;
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            to_device <= cmd_data;
            state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: state <= ST_HOLD;
        ST_HOLD: begin
          gap_cnt <= GAP_LOAD;
          state   <= ST_GAP;
        end
        ST_GAP: begin
          if (gap_cnt == '0) state <= ST_IDLE;
          else gap_cnt <= gap_cnt - 8'd1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // an issue and a frame end in one cycle cancel out
  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding <= '0;
      frames_done <= '0;
    end else begin
      if (frame_end) frames_done <= frames_done + 16'd1;
      if (issue && !frame_end)
        outstanding <= outstanding + OW'(1);
      else if (frame_end && !issue && outstanding != '0)
        outstanding <= outstanding - OW'(1);
    end
  end

endmodule

// File: tb/tb_spi_cmd_scheduler.sv
// Bench for spi_cmd_scheduler: vector table, directed corner
// sequences and random traffic against a timing model.
module tb_spi_cmd_scheduler;
  import spi_pkg::*;

  localparam int TXD = DEF_TX_DEPTH;
  localparam int MG  = DEF_MIN_GAP;
  localparam int OW  = $clog2(TXD + 1);
  localparam logic [31:0] WA = 32'hA5A5_0F0F;
  localparam logic [31:0] WB = 32'h1234_5678;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic [31:0]   cmd_data = '0;
  logic          spi_cs = 1'b0;
  logic          cmd_ready;
  logic          trigger;
  logic          idle;
  logic [31:0]   to_device;
  logic [OW-1:0] outstanding;
  logic [15:0]   frames_done;

  spi_cmd_scheduler #(
    .TX_DEPTH(TXD),
    .MIN_GAP (MG)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_data   (cmd_data),
    .cmd_ready  (cmd_ready),
    .spi_cs     (spi_cs),
    .trigger    (trigger),
    .to_device  (to_device),
    .outstanding(outstanding),
    .frames_done(frames_done),
    .idle       (idle)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // timing model: cycle index arithmetic plus a word queue
  longint      cyc = 0;
  longint      next_ok = 0;
  longint      trig_at = -1;
  int          m_out = 0;
  logic [15:0] m_fd = '0;
  logic [31:0] m_dev = '0;
  logic        m_csq = 1'b1;
  bit          m_known = 0;
  logic [31:0] sb[$];

  logic          s_ready, s_trig, s_idle;
  logic [31:0]   s_dev;
  logic [OW-1:0] s_out;
  logic [15:0]   s_fd;

  logic [31:0] words[16];
  int          widx = 0;
  int          nwords = 0;
  bit          feed = 0;

  typedef struct packed {
    logic        v;
    logic [31:0] d;
    logic        cs;
    logic        e_ready;
    logic        e_trig;
    logic [31:0] e_dev;
    logic [7:0]  e_out;
    logic [15:0] e_fd;
  } vec_t;

  vec_t vec[12];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic bit m_ready();
    return !rst && m_known && cyc >= next_ok && m_out < TXD;
  endfunction

  function automatic bit m_trig();
    return !rst && cyc == trig_at;
  endfunction

  task automatic model_check();
    chk("m_ready", 32'(cmd_ready), 32'(m_ready()));
    chk("m_trigger", 32'(trigger), 32'(m_trig()));
    if (m_known) begin
      chk("m_to_device", to_device, m_dev);
      chk("m_outstanding", 32'(outstanding), 32'(m_out));
      chk("m_frames_done", 32'(frames_done), 32'(m_fd));
      chk("m_idle", 32'(idle), 32'(cyc >= next_ok && m_out == 0));
    end
    if (trigger === 1'b1) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL sb_order actual=trigger required=no_pending_word");
      end else begin
        chk("sb_order", to_device, sb.pop_front());
      end
    end
  endtask

  task automatic model_step();
    bit acc, fe, iss;
    if (rst) begin
      m_known = 1;
      m_out   = 0;
      m_fd    = '0;
      m_dev   = '0;
      m_csq   = 1'b1;
      next_ok = cyc + 1;
      trig_at = -1;
      sb.delete();
    end else begin
      acc   = cmd_valid && m_ready();
      fe    = spi_cs && !m_csq;
      iss   = (cyc == trig_at);
      m_csq = spi_cs;
      if (fe) m_fd = m_fd + 16'd1;
      if (iss && !fe) m_out++;
      else if (fe && !iss && m_out > 0) m_out--;
      if (acc) begin
        m_dev   = cmd_data;
        trig_at = cyc + 1;
        next_ok = cyc + MG + 2;
        sb.push_back(cmd_data);
      end
    end
    cyc++;
  endtask

  task automatic tick();
    @(negedge clk);
    s_ready = cmd_ready;
    s_trig  = trigger;
    s_idle  = idle;
    s_dev   = to_device;
    s_out   = outstanding;
    s_fd    = frames_done;
    model_check();
    @(posedge clk);
    model_step();
    #1;
    if (feed && cmd_valid && s_ready) begin
      widx++;
      if (widx < nwords) cmd_data = words[widx];
      else begin
        cmd_valid = 1'b0;
        feed = 0;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cmd_valid = 1'b0;
    spi_cs = 1'b0;
    feed = 0;
    tick();
    rst = 1'b0;
  endtask

  task automatic start_feed(input int n);
    for (int i = 0; i < 16; i++) words[i] = 32'hC0DE_0000 + 32'(i);
    widx = 0;
    nwords = n;
    cmd_data = words[0];
    cmd_valid = 1'b1;
    feed = 1;
  endtask

  initial begin
    int ntr;
    int last_t;
    vec[0]  = '{1'b1, WA, 1'b0, 1'b1, 1'b0, 32'h0, 8'd0, 16'd0};
    vec[1]  = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b1, WA, 8'd0, 16'd0};
    vec[2]  = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b0, WA, 8'd1, 16'd0};
    vec[3]  = '{1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, WA, 8'd1, 16'd0};
    vec[4]  = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b0, WA, 8'd1, 16'd0};
    vec[5]  = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b0, WA, 8'd1, 16'd0};
    vec[6]  = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b0, WA, 8'd0, 16'd1};
    vec[7]  = '{1'b1, WB, 1'b0, 1'b1, 1'b0, WA, 8'd0, 16'd1};
    vec[8]  = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b1, WB, 8'd0, 16'd1};
    vec[9]  = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b0, WB, 8'd1, 16'd1};
    vec[10] = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b0, WB, 8'd1, 16'd1};
    vec[11] = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b0, WB, 8'd1, 16'd1};

    tick();
    tick();
    chk("rst_ready", 32'(s_ready), 32'd0);
    chk("rst_trigger", 32'(s_trig), 32'd0);
    rst = 1'b0;
    tick();
    chk("reset_to_device", s_dev, 32'd0);
    chk("reset_outstanding", 32'(s_out), 32'd0);
    chk("reset_frames_done", 32'(s_fd), 32'd0);
    chk("reset_idle", 32'(s_idle), 32'd1);
    chk("reset_ready", 32'(s_ready), 32'd1);

    for (int i = 0; i < 12; i++) begin
      cmd_valid = vec[i].v;
      cmd_data  = vec[i].d;
      spi_cs    = vec[i].cs;
      tick();
      chk($sformatf("vec%0d_ready", i), 32'(s_ready), 32'(vec[i].e_ready));
      chk($sformatf("vec%0d_trig", i), 32'(s_trig), 32'(vec[i].e_trig));
      chk($sformatf("vec%0d_dev", i), s_dev, vec[i].e_dev);
      chk($sformatf("vec%0d_out", i), 32'(s_out), 32'(vec[i].e_out));
      chk($sformatf("vec%0d_fd", i), 32'(s_fd), 32'(vec[i].e_fd));
    end
    cmd_valid = 1'b0;
    spi_cs = 1'b0;

    // ten words offered, credits run out after eight
    do_reset();
    start_feed(10);
    ntr = 0;
    last_t = 0;
    for (int t = 0; t < 50; t++) begin
      tick();
      if (s_trig) begin
        if (ntr > 0) chk("fill_spacing", 32'(t - last_t), 32'(MG + 2));
        last_t = t;
        ntr++;
      end
    end
    chk("fill_triggers", 32'(ntr), 32'd8);
    chk("fill_ready", 32'(s_ready), 32'd0);
    chk("fill_outstanding", 32'(s_out), 32'(TXD));

    spi_cs = 1'b1;
    tick();
    chk("credit_ready_before", 32'(s_ready), 32'd0);
    spi_cs = 1'b0;
    tick();
    chk("credit_outstanding", 32'(s_out), 32'(TXD - 1));
    chk("credit_frames_done", 32'(s_fd), 32'd1);
    chk("credit_ready", 32'(s_ready), 32'd1);
    tick();
    chk("credit_trigger", 32'(s_trig), 32'd1);
    chk("credit_word9", s_dev, words[8]);
    feed = 0;
    cmd_valid = 1'b0;
    tick();
    chk("credit_refill", 32'(s_out), 32'(TXD));

    // issue and frame end land in the same cycle
    do_reset();
    start_feed(3);
    repeat (16) tick();
    chk("coinc_pre_out", 32'(s_out), 32'd3);
    cmd_valid = 1'b1;
    cmd_data = 32'h0000_0077;
    tick();
    chk("coinc_accept", 32'(s_ready), 32'd1);
    cmd_valid = 1'b0;
    spi_cs = 1'b1;
    tick();
    chk("coinc_trigger", 32'(s_trig), 32'd1);
    chk("coinc_out_now", 32'(s_out), 32'd3);
    spi_cs = 1'b0;
    tick();
    chk("coinc_out_after", 32'(s_out), 32'd3);
    chk("coinc_frames_done", 32'(s_fd), 32'd1);

    // frame counter wrap, with no credits outstanding
    do_reset();
    force dut.frames_done = 16'hFFFE;
    m_fd = 16'hFFFE;
    #1;
    release dut.frames_done;
    tick();
    spi_cs = 1'b1;
    tick();
    spi_cs = 1'b0;
    tick();
    chk("wrap_ffff", 32'(s_fd), 32'h0000_FFFF);
    spi_cs = 1'b1;
    tick();
    spi_cs = 1'b0;
    tick();
    chk("wrap_zero", 32'(s_fd), 32'd0);
    chk("underflow_out", 32'(s_out), 32'd0);

    // reset while holding the fifth word
    do_reset();
    start_feed(5);
    ntr = 0;
    for (int i = 0; i < 40 && ntr < 5; i++) begin
      tick();
      if (s_trig) ntr++;
    end
    chk("hold_five_triggers", 32'(ntr), 32'd5);
    rst = 1'b1;
    tick();
    chk("hold_out_before", 32'(s_out), 32'd5);
    chk("hold_rst_ready", 32'(s_ready), 32'd0);
    chk("hold_rst_trig", 32'(s_trig), 32'd0);
    rst = 1'b0;
    tick();
    chk("hold_after_out", 32'(s_out), 32'd0);
    chk("hold_after_trig", 32'(s_trig), 32'd0);
    chk("hold_after_dev", s_dev, 32'd0);
    chk("hold_after_idle", 32'(s_idle), 32'd1);

    // reset during ISSUE suppresses the strobe
    do_reset();
    cmd_valid = 1'b1;
    cmd_data = 32'h0BAD_F00D;
    tick();
    cmd_valid = 1'b0;
    rst = 1'b1;
    tick();
    chk("issue_rst_trig", 32'(s_trig), 32'd0);
    rst = 1'b0;
    tick();
    chk("issue_rst_idle", 32'(s_idle), 32'd1);
    chk("issue_rst_dev", s_dev, 32'd0);

    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      cmd_valid = ($urandom_range(0, 9) < 6);
      cmd_data = $urandom();
      if ($urandom_range(0, 3) == 0) spi_cs = ~spi_cs;
      tick();
    end
    rst = 1'b0;
    cmd_valid = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/spi_cmd_scheduler.md
SPI_CMD_SCHEDULER -- requirements
Module: spi_cmd_scheduler

Interface
REQ-001 SHALL have parameter TX_DEPTH, default 8: word capacity of the downstream SPI controller's transmit FIFO; credit ceiling.
REQ-002 SHALL have parameter MIN_GAP, default 2: minimum idle clocks between consecutive trigger pulses, legal range 2..255.
REQ-003 SHALL have port clk  input  1  system clock; one clock, all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port cmd_valid  input  1  host word available.
REQ-006 SHALL have port cmd_data  input  32  host word to transmit.
REQ-007 SHALL have port cmd_ready  output  1  scheduler accepts cmd_data this cycle.
REQ-008 SHALL have port spi_cs  input  1  chip select from the SPI controller, active-low; its 0->1 edge marks frame end.
REQ-009 SHALL have port trigger  output  1  one-clock write strobe to the SPI controller.
REQ-010 SHALL have port to_device  output  32  word presented to the SPI controller.
REQ-011 SHALL have port outstanding  output  $clog2(TX_DEPTH+1)  words issued but not yet framed.
REQ-012 SHALL have port frames_done  output  16  count of completed frames, wraps 0xFFFF->0x0000.
REQ-013 SHALL have port idle  output  1  high when state IDLE and outstanding==0.

Function
REQ-014 SHALL implement FSM states IDLE, ISSUE, HOLD, GAP.
REQ-015 IDLE: cmd_ready=1 iff outstanding<TX_DEPTH; on cmd_valid&&cmd_ready latch cmd_data into to_device, go ISSUE.
REQ-016 ISSUE: trigger=1 for exactly this one cycle, outstanding increments, go HOLD.
REQ-017 HOLD: to_device held unchanged one further cycle (controller samples data one clock after trigger), go GAP.
REQ-018 GAP: stay MIN_GAP-1 cycles counting from HOLD exit, then go IDLE; cmd_ready=0 throughout ISSUE, HOLD, GAP.
REQ-019 to_device SHALL change only on an IDLE acceptance; otherwise it holds the last accepted word.
REQ-020 Handshake latency: acceptance in cycle N -> trigger in cycle N+1; back-to-back words give trigger spacing of MIN_GAP+2 clocks.
REQ-021 Frame end SHALL be detected from a one-flop registered copy of spi_cs: rising edge = spi_cs==1 && spi_cs_q==0.
REQ-022 On frame end: outstanding decrements by 1 and frames_done increments by 1 in the following cycle.
REQ-023 Simultaneous ISSUE and frame end in one cycle: outstanding unchanged, frames_done still increments.
REQ-024 Frame end with outstanding==0: outstanding stays 0 (no underflow), frames_done still increments.
REQ-025 outstanding==TX_DEPTH: cmd_ready=0 and no acceptance until a frame end lowers it.
REQ-026 cmd_valid deasserted before acceptance SHALL have no effect; no word is dropped or duplicated.

Reset
REQ-027 While rst=1 at a clock edge: state IDLE, trigger=0, to_device=0, outstanding=0, frames_done=0, gap counter=0, spi_cs_q=1.
REQ-028 cmd_ready SHALL be 0 during any cycle in which rst=1.
REQ-029 Reset mid-operation (any state) SHALL return to IDLE next cycle with no trigger pulse emitted in that cycle.

Structure
REQ-030 FSM state encoding and the default TX_DEPTH/MIN_GAP values SHALL reside in a shared package spi_pkg.
REQ-031 Block SHALL be a single module with no sub-modules; the edge detector is inline.

Verification
REQ-032 Single word 0xA5A5_0F0F, MIN_GAP=2 -> one trigger pulse one cycle after accept, to_device=0xA5A5_0F0F for trigger cycle and next, outstanding=1.
REQ-033 cmd_valid held high with 10 words, TX_DEPTH=8, spi_cs held 0 -> exactly 8 triggers spaced 4 clocks, cmd_ready=0 afterwards, outstanding=8.
REQ-034 From REQ-033 state, one spi_cs 0->1 pulse -> outstanding=7, frames_done=1, 9th word accepted and triggered.
REQ-035 spi_cs rising edge in the same cycle as trigger, outstanding=3 before -> outstanding=3, frames_done incremented.
REQ-036 frames_done preloaded by 65535 frame ends, one more frame end -> frames_done=0x0000.
REQ-037 rst asserted during HOLD with outstanding=5 -> next cycle IDLE, outstanding=0, trigger=0, to_device=0, idle=1 after release.
